// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory bus arbiter.
// Holds the FSM state enum and the default NUM_REQ/ADDR_W/DATA_W values.
package mem_arb_pkg;

  localparam int NUM_REQ_D = 3;
  localparam int ADDR_W_D  = 32;
  localparam int DATA_W_D  = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational picker: scans i_req from i_start upward, wrapping.
// Ports: i_req, i_start in; o_gnt (one-hot), o_idx, o_any out.
module arb_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_start,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(i_start) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates fetch/load/store requesters onto one memory port,
// one transaction outstanding at a time (IDLE -> ISSUE -> WAIT).
// Ports: clk, reset (sync, active high); req_* / resp_* requester side;
// mem_* memory side; protocol_err sticky on a response outside WAIT.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module memory_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      protocol_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [IDX_W-1:0]    r_owner;
  logic                r_perr;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic [IDX_W-1:0]    w_start;
  logic                w_accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    r_last;

  // Search begins one past the last winner, wrapping to 0.
  assign w_start = (int'(r_last) == NUM_REQ-1) ? '0 : r_last + 1'b1;

  always_ff @(posedge clk) begin
    if (reset)
      r_last <= IDX_W'(NUM_REQ-1);
    else if (w_accept)
      r_last <= w_idx;
  end
`else
  assign w_start = '0;
`endif

  arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_start (w_start),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept = (r_state == IDLE) && w_any && !reset;

  always_comb begin
    w_next        = r_state;
    req_ready     = '0;
    mem_req_valid = 1'b0;
    resp_valid    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready = w_gnt;
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          w_next = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid) begin
          resp_valid = NUM_REQ'(1) << r_owner;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // Outputs are quiet while reset is held, whatever the state.
    if (reset) begin
      req_ready     = '0;
      mem_req_valid = 1'b0;
      resp_valid    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_owner <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
        r_we    <= req_we[w_idx];
        r_wdata <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
        r_owner <= w_idx;
      end
      if (mem_resp_valid && r_state != WAIT)
        r_perr <= 1'b1;
    end
  end

  assign mem_addr     = r_addr;
  assign mem_we       = r_we;
  assign mem_wdata    = r_wdata;
  assign resp_rdata   = mem_rdata;
  assign protocol_err = r_perr;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: grants and responses are
// queued by the stimulus and checked by a negedge monitor.
module tb_memory_bus_arbiter;

  logic          clk = 0;
  logic          reset;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [95:0]   req_addr;
  logic [2:0]    req_we;
  logic [191:0]  req_wdata;
  logic [2:0]    resp_valid;
  logic [63:0]   resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_addr;
  logic          mem_we;
  logic [63:0]   mem_wdata;
  logic          mem_resp_valid;
  logic [63:0]   mem_rdata;
  logic          protocol_err;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0]  gq[$];
  logic [2:0]  rq_v[$];
  logic [63:0] rq_d[$];

  logic [31:0] exp_addr  [3] = '{32'h100, 32'h200, 32'h300};
  logic [63:0] exp_wdata [3] = '{64'hA0, 64'hA1, 64'hA2};

  always #5 clk = ~clk;

  memory_bus_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_we         (req_we),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .protocol_err   (protocol_err)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any grant or response must match the head of its queue.
  always @(negedge clk) begin
    if (req_ready !== 3'b000) begin
      if (gq.size() == 0)
        chk("unexpected_grant", {61'd0, req_ready}, 64'd0);
      else
        chk("grant", {61'd0, req_ready}, {61'd0, gq.pop_front()});
    end
    if (resp_valid !== 3'b000) begin
      if (rq_v.size() == 0) begin
        chk("unexpected_resp", {61'd0, resp_valid}, 64'd0);
      end else begin
        chk("resp_valid", {61'd0, resp_valid}, {61'd0, rq_v.pop_front()});
        chk("resp_rdata", resp_rdata, rq_d.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_txn(input logic [2:0] vld, input logic [2:0] we,
                         input int g, input int stall,
                         input logic [63:0] rd, input bit hold);
    req_valid = vld;
    req_we    = we;
    gq.push_back(3'b001 << g);
    rq_v.push_back(3'b001 << g);
    rq_d.push_back(rd);
    @(negedge clk);
    chk("idle_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    step();
    if (!hold) req_valid = 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("stall_addr", {32'd0, mem_addr}, {32'd0, exp_addr[g]});
      chk("stall_we", {63'd0, mem_we}, {63'd0, we[g]});
      chk("stall_wdata", mem_wdata, exp_wdata[g]);
      chk("stall_ready", {61'd0, req_ready}, 64'd0);
      step();
    end
    mem_req_ready = 1;
    @(negedge clk);
    chk("issue_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("issue_addr", {32'd0, mem_addr}, {32'd0, exp_addr[g]});
    chk("issue_we", {63'd0, mem_we}, {63'd0, we[g]});
    chk("issue_wdata", mem_wdata, exp_wdata[g]);
    step();
    mem_req_ready  = 0;
    mem_resp_valid = 1;
    mem_rdata      = rd;
    @(negedge clk);
    chk("wait_ready", {61'd0, req_ready}, 64'd0);
    step();
    mem_resp_valid = 0;
    mem_rdata      = 0;
  endtask

  initial begin
    int g4[4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    g4 = '{0, 1, 2, 0};
`else
    g4 = '{0, 0, 0, 0};
`endif
    reset          = 1;
    req_valid      = 3'b111;
    req_addr       = {32'h300, 32'h200, 32'h100};
    req_we         = 0;
    req_wdata      = {64'hA2, 64'hA1, 64'hA0};
    mem_req_ready  = 0;
    mem_resp_valid = 1;
    mem_rdata      = 64'h55;
    step();
    @(negedge clk);
    chk("rst_req_ready", {61'd0, req_ready}, 64'd0);
    chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_resp_valid", {61'd0, resp_valid}, 64'd0);
    chk("rst_perr", {63'd0, protocol_err}, 64'd0);
    step();
    reset          = 0;
    req_valid      = 0;
    mem_resp_valid = 0;
    mem_rdata      = 0;
    @(negedge clk);
    chk("post_rst_perr", {63'd0, protocol_err}, 64'd0);
    step();

    run_txn(3'b001, 3'b000, 0, 0, 64'hDEAD, 0);
    run_txn(3'b100, 3'b100, 2, 0, 64'h0, 0);
    run_txn(3'b010, 3'b000, 1, 5, 64'h1234_5678, 0);

    do_reset();
    for (int i = 0; i < 4; i++)
      run_txn(3'b111, 3'b000, g4[i], 0, 64'h100 + 64'(i), 1);
    req_valid = 0;
    do_reset();
    run_txn(3'b110, 3'b000, 1, 0, 64'h77, 0);
    run_txn(3'b011, 3'b000, 0, 0, 64'h88, 0);
    @(negedge clk);
    chk("no_perr_yet", {63'd0, protocol_err}, 64'd0);
    step();

    mem_resp_valid = 1;
    mem_rdata      = 64'hBEEF;
    step();
    mem_resp_valid = 0;
    mem_rdata      = 0;
    @(negedge clk);
    chk("spurious_perr", {63'd0, protocol_err}, 64'd1);
    step();
    run_txn(3'b100, 3'b000, 2, 0, 64'h99, 0);
    @(negedge clk);
    chk("perr_sticky", {63'd0, protocol_err}, 64'd1);
    step();

    do_reset();
    @(negedge clk);
    chk("perr_cleared", {63'd0, protocol_err}, 64'd0);
    step();
    req_valid = 3'b001;
    gq.push_back(3'b001);
    step();
    req_valid     = 0;
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    reset = 1;
    @(negedge clk);
    chk("wait_rst_resp", {61'd0, resp_valid}, 64'd0);
    chk("wait_rst_memv", {63'd0, mem_req_valid}, 64'd0);
    step();
    reset          = 0;
    mem_resp_valid = 1;
    mem_rdata      = 64'hCAFE;
    step();
    mem_resp_valid = 0;
    mem_rdata      = 0;
    @(negedge clk);
    chk("rst_wait_perr", {63'd0, protocol_err}, 64'd1);
    step();
    run_txn(3'b001, 3'b000, 0, 0, 64'h4242, 0);

    step();
    chk("grant_q_empty", 64'(gq.size()), 64'd0);
    chk("resp_q_empty", 64'(rq_v.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters; index 0 = fetch, 1 = load, 2 = store.
REQ-002 Parameter ADDR_W, default 32, memory address width in bits.
REQ-003 Parameter DATA_W, default 64, memory data width in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester request accepted (one-hot or zero).
REQ-008 req_addr  input  NUM_REQ*ADDR_W  packed request addresses; slice i belongs to requester i.
REQ-009 req_we  input  NUM_REQ  per-requester write enable (1 = write).
REQ-010 req_wdata  input  NUM_REQ*DATA_W  packed write data.
REQ-011 resp_valid  output  NUM_REQ  one-cycle response pulse to the owning requester.
REQ-012 resp_rdata  output  DATA_W  read data, shared by all requesters.
REQ-013 mem_req_valid / mem_req_ready  output / input  1 / 1  memory-side request handshake.
REQ-014 mem_addr, mem_we, mem_wdata  output  ADDR_W, 1, DATA_W  memory-side request fields.
REQ-015 mem_resp_valid / mem_rdata  input  1 / DATA_W  memory-side response; one response per request, reads and writes alike.
REQ-016 protocol_err  output  1  sticky flag for unexpected memory response.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT; exactly one memory transaction outstanding at any time.
REQ-018 IDLE: when any req_valid is high, req_ready is combinationally one-hot on the winner; addr/we/wdata/owner are latched; next state ISSUE.
REQ-019 IDLE with no req_valid: req_ready = 0, state holds.
REQ-020 req_ready is 0 in ISSUE and WAIT; requesters hold req_valid and fields stable until accepted.
REQ-021 ISSUE: mem_req_valid = 1 with latched fields; on mem_req_ready = 1, go to WAIT; otherwise hold, fields unchanged.
REQ-022 WAIT: on mem_resp_valid = 1, resp_valid[owner] = 1 in the same cycle, resp_rdata = mem_rdata (combinational pass-through), next state IDLE.
REQ-023 Minimum latency: accept in cycle N, mem_req_valid in cycle N+1, earliest response in N+2, next accept in N+3.
REQ-024 resp_rdata is don't-care when resp_valid is zero; resp_valid is never asserted outside WAIT.
REQ-025 mem_resp_valid in IDLE or ISSUE is ignored for routing and sets protocol_err to 1 until reset.
REQ-026 Fixed-priority mode: lowest asserted index wins.

Reset
REQ-027 Reset: state = IDLE, latched fields = 0, owner = 0, RR pointer = NUM_REQ-1, protocol_err = 0.
REQ-028 During reset: req_ready = 0, resp_valid = 0, mem_req_valid = 0.
REQ-029 Reset mid-transaction abandons it; no resp_valid is produced for it. The memory side shares the same reset.

Configuration
REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. The search starts at (last_grant+1) mod NUM_REQ and wraps. last_grant updates only on accept.
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-026; the RR pointer register is not built.

Structure
REQ-032 Package mem_arb_pkg holds the FSM state enum (IDLE, ISSUE, WAIT) and default ADDR_W/DATA_W/NUM_REQ constants.
REQ-033 One sub-module, arb_picker, is combinational. It takes the request vector and start pointer and returns the one-hot grant plus the index, and is shared by both modes.

Verification
REQ-034 Single read: req_valid=001, addr=0x100, mem_req_ready=1, mem_resp_valid two cycles later with rdata=0xDEAD -> resp_valid=001, resp_rdata=0xDEAD, back in IDLE.
REQ-035 Contention, fixed priority: req_valid=111 held -> grants 0,0,0... Requester 0 wins every round while it stays asserted.
REQ-036 Contention, round robin: req_valid=111 held for 3 transactions -> grant order 0,1,2, then 0.
REQ-037 Backpressure: mem_req_ready=0 for 5 cycles in ISSUE -> mem_addr/we/wdata stable, req_ready=000 throughout, issue completes on the 6th cycle.
REQ-038 Spurious response: mem_resp_valid=1 in IDLE -> protocol_err=1 and stays 1, resp_valid=000.
REQ-039 Reset in WAIT: reset for 1 cycle, then mem_resp_valid=1 -> no resp_valid, state IDLE, protocol_err=1.
